amp_gain_meter: RTL and testbench
=================================

# amp_gain_meter

Digital gain-measurement stage downstream of the selective amplifier. It consumes paired ADC samples of the amplifier's input and output nodes and accumulates their magnitudes over a fixed window. It then reports the gain in dB, 20·log10(Σ|out| / Σ|in|), as signed Q8.8. It is the on-chip counterpart of the testbench `Gain` equation and drives the tuning/characterisation controller.

## Interface
- `W`, 12: sample width, signed two's complement.
- `LOG2_WIN`, 8: log2 of window length; N = 2^LOG2_WIN samples.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to begin a measurement.
- `sample_valid` in 1: `in_sample` and `out_sample` are valid this cycle.
- `in_sample` in W: amplifier input-node sample.
- `out_sample` in W: amplifier output-node sample.
- `busy` out 1: measurement in progress.
- `result_valid` out 1: one-cycle pulse when `gain_db` updates.
- `gain_db` out 16: signed Q8.8 gain in dB; held until the next result.
- `zero_flag` out 1: one of the sums was 0 and the result is saturated; held with `gain_db`.

## Operation
- Reset values: `busy`=0, `result_valid`=0, `gain_db`=0, `zero_flag`=0, sums=0, counter=0, state IDLE.
- FSM states: IDLE → ACCUM → LOG → SCALE → IDLE.
- IDLE:
  - `start`=1 clears both sums and the sample counter, then enters ACCUM. `busy`=1 from the next cycle.
  - `sample_valid` is ignored.
- ACCUM:
  - Each cycle with `sample_valid` adds |in_sample| to sum_in and |out_sample| to sum_out, and increments the counter.
  - |−2^(W−1)| = 2^(W−1) exactly, so the magnitude is W bits unsigned.
  - Sum width is W+LOG2_WIN bits; overflow is impossible.
  - On acceptance of the N-th sample, go to LOG.
  - `start` is ignored in every non-IDLE state.
- LOG (1 cycle): register l_in = log2a(sum_in) and l_out = log2a(sum_out).
  - log2a(x) for x>0: e = index of the most significant 1. Fraction = the 8 bits directly below the MSB, zero-padded on the right if e<8. Result = e·256 + fraction (unsigned, 8 fractional bits).
  - Each sum also produces a zero indicator.
- SCALE (1 cycle):
  - d = l_out − l_in (signed); p = d·1541, which is 20·log10(2) = 6.0206 in Q8.8.
  - `gain_db` = p >>> 8 (arithmetic shift, floor), saturated to [−32768, 32767].
  - If sum_out=0: `gain_db` = −32768 and `zero_flag`=1. This takes precedence if both sums are 0.
  - Else if sum_in=0: `gain_db` = 32767 and `zero_flag`=1.
  - Otherwise `zero_flag`=0.
  - Assert `result_valid`, return to IDLE.
- `rst` asserted in any state aborts the measurement and restores all reset values, including clearing the held `gain_db`.

## Timing
- The measurement takes N accepted samples; gaps in `sample_valid` stretch the window without limit.
- Latency: with the last sample accepted at edge k, LOG registers at k+1 and SCALE registers at k+2.
  - `result_valid` is high for exactly the cycle after edge k+2.
  - `busy` falls at edge k+2, coincident with `result_valid` rising.
- `start` is accepted in the same cycle `result_valid` is high, because the FSM is already in IDLE.
- A `start` cycle's `sample_valid` is not counted; the first counted sample is at the cycle after `start`.

## Structure
- Package `amp_meas_pkg` holds:
  - `DB_PER_OCT_Q8` = 1541
  - `LOG_FRAC_BITS` = 8
  - the FSM state enum {IDLE, ACCUM, LOG, SCALE}
- Sub-module `log2_approx` (parameter input width): combinational leading-one detector plus fraction extractor, outputs value and is_zero. It is instantiated twice, for in and out.
- Top level holds the counter, both accumulators, the FSM, the multiplier and the saturation logic.

## Test plan
- Defaults, `in_sample` alternating ±100, `out_sample` alternating ±1000, 256 samples:
  - sums 25600 / 256000; l_in = 14·256+144, l_out = 17·256+244, d = 868.
  - Expect `gain_db` = 5224 (0x1468), `zero_flag`=0, one `result_valid` pulse 3 edges after the last sample.
- Identical in/out of ±500, including −2048 samples → `gain_db` = 0.
- `out_sample` all 0, in ±100 → `gain_db` = −32768, `zero_flag`=1. `in_sample` all 0, out ±100 → 32767, `zero_flag`=1.
- `sample_valid` toggling every other cycle and a second `start` pulse mid-ACCUM → result identical to the gap-free run; the second `start` is ignored and `busy` stays high.
- `rst` pulse after 100 samples → next cycle `busy`=0, `gain_db`=0. A new `start` then gives the correct full-window result, with no stale accumulation.
- Back-to-back: `start` asserted in the `result_valid` cycle → second measurement begins immediately and yields the same value for the same stimulus.

Source files
------------

// File: rtl/amp_meas_pkg.sv
// Shared constants and FSM state type for the amplifier gain meter.
`timescale 1ns/1ps
package amp_meas_pkg;

  localparam int DB_PER_OCT_Q8 = 1541;
  localparam int LOG_FRAC_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    LOG   = 2'd2,
    SCALE = 2'd3
  } meas_state_e;

endpackage

// File: rtl/log2_approx.sv
// Piecewise-linear log2: MSB index as integer part, the bits below it as fraction.
`timescale 1ns/1ps
module log2_approx
  import amp_meas_pkg::*;
#(
  parameter int IW = 20,
  parameter int EW = $clog2(IW),
  parameter int OW = EW + LOG_FRAC_BITS
) (
  input  logic [IW-1:0] x,
  output logic [OW-1:0] value,
  output logic          is_zero
);

  logic [EW-1:0]            msb;
  logic [LOG_FRAC_BITS-1:0] frac;

  always_comb begin
    msb = '0;
    for (int i = 0; i < IW; i++) begin
      if (x[i]) msb = EW'(i);
    end
  end

  // Fraction bits that would fall below bit 0 are zero-filled.
  always_comb begin
    frac = '0;
    for (int j = 0; j < LOG_FRAC_BITS; j++) begin
      int idx;
      idx = int'(msb) - LOG_FRAC_BITS + j;
      if (idx >= 0) frac[j] = x[idx];
    end
  end

  assign value   = {msb, frac};
  assign is_zero = ~|x;

endmodule

// File: rtl/amp_gain_meter.sv
// Windowed magnitude accumulation of amplifier in/out samples, reported as
// gain in dB (signed Q8.8) via log2 difference scaled by 20*log10(2).
//
// state | meaning
// IDLE  | waiting for start, result held
// ACCUM | summing |in| and |out| over N accepted samples
// LOG   | registering log2 of both sums
// SCALE | dB scaling, saturation, result_valid issue
`timescale 1ns/1ps
module amp_gain_meter
  import amp_meas_pkg::*;
#(
  parameter int W        = 12,
  parameter int LOG2_WIN = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sample_valid,
  input  logic signed [W-1:0] in_sample,
  input  logic signed [W-1:0] out_sample,
  output logic                busy,
  output logic                result_valid,
  output logic signed [15:0]  gain_db,
  output logic                zero_flag
);

  localparam int SW = W + LOG2_WIN;
  localparam int LW = $clog2(SW) + LOG_FRAC_BITS;
  localparam int PW = LW + 1 + 12;
  localparam logic signed [PW-1:0] K_DB   = PW'(DB_PER_OCT_Q8);
  localparam logic signed [PW-1:0] SAT_HI = PW'(32767);
  localparam logic signed [PW-1:0] SAT_LO = -PW'(32768);

  meas_state_e         state_q, state_d;
  logic [LOG2_WIN-1:0] cnt_q;
  logic [SW-1:0]       sum_in_q, sum_out_q;
  logic [LW-1:0]       l_in_q, l_out_q;
  logic                z_in_q, z_out_q;

  logic [W-1:0]        in_mag, out_mag;
  logic                accept, last;
  logic [LW-1:0]       l_in_c, l_out_c;
  logic                z_in_c, z_out_c;
  logic signed [LW:0]  d;
  logic signed [PW-1:0] p, p_sh;
  logic signed [15:0]  gain_c;
  logic                zf_c;

  // Negating -2^(W-1) wraps to 2^(W-1), which is exact as W-bit unsigned.
  assign in_mag  = in_sample[W-1]  ? (~in_sample)  + W'(1) : in_sample;
  assign out_mag = out_sample[W-1] ? (~out_sample) + W'(1) : out_sample;

  assign accept = (state_q == ACCUM) && sample_valid;
  assign last   = accept && (cnt_q == '1);
  assign busy   = (state_q != IDLE);

  log2_approx #(.IW(SW), .OW(LW)) u_log_in (
    .x       (sum_in_q),
    .value   (l_in_c),
    .is_zero (z_in_c)
  );

  log2_approx #(.IW(SW), .OW(LW)) u_log_out (
    .x       (sum_out_q),
    .value   (l_out_c),
    .is_zero (z_out_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (last) state_d = LOG;
      LOG:     state_d = SCALE;
      SCALE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    d    = $signed({1'b0, l_out_q}) - $signed({1'b0, l_in_q});
    p    = PW'(d) * K_DB;
    p_sh = p >>> LOG_FRAC_BITS;
    zf_c = 1'b0;
    if (p_sh > SAT_HI)      gain_c = 16'sh7fff;
    else if (p_sh < SAT_LO) gain_c = 16'sh8000;
    else                    gain_c = p_sh[15:0];
    // An empty output sum wins over an empty input sum.
    if (z_out_q) begin
      gain_c = 16'sh8000;
      zf_c   = 1'b1;
    end else if (z_in_q) begin
      gain_c = 16'sh7fff;
      zf_c   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      sum_in_q     <= '0;
      sum_out_q    <= '0;
      l_in_q       <= '0;
      l_out_q      <= '0;
      z_in_q       <= 1'b0;
      z_out_q      <= 1'b0;
      gain_db      <= '0;
      zero_flag    <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= (state_q == SCALE);
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q     <= '0;
            sum_in_q  <= '0;
            sum_out_q <= '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            cnt_q     <= cnt_q + LOG2_WIN'(1);
            sum_in_q  <= sum_in_q + SW'(in_mag);
            sum_out_q <= sum_out_q + SW'(out_mag);
          end
        end
        LOG: begin
          l_in_q  <= l_in_c;
          l_out_q <= l_out_c;
          z_in_q  <= z_in_c;
          z_out_q <= z_out_c;
        end
        SCALE: begin
          gain_db   <= gain_c;
          zero_flag <= zf_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_amp_gain_meter.sv
// Directed bench for amp_gain_meter with an expected-result scoreboard.
`timescale 1ns/1ps
module tb_amp_gain_meter;

  localparam int N = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sample_valid;
  logic [11:0] in_sample, out_sample;
  logic        busy, result_valid, zero_flag;
  logic [15:0] gain_db;

  int n_checks = 0;
  int n_pass   = 0;
  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];

  amp_gain_meter #(.W(12), .LOG2_WIN(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sample_valid (sample_valid),
    .in_sample    (in_sample),
    .out_sample   (out_sample),
    .busy         (busy),
    .result_valid (result_valid),
    .gain_db      (gain_db),
    .zero_flag    (zero_flag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (result_valid) got_q.push_back({zero_flag, gain_db});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic int gen(input int kind, input int i, input bit is_out);
    int s;
    s = (i % 2 == 1) ? -1 : 1;
    case (kind)
      0:       return is_out ? s * 1000 : s * 100;
      1:       return (i % 16 == 5) ? -2048 : s * 500;
      2:       return is_out ? 0 : s * 100;
      3:       return is_out ? s * 100 : 0;
      default: return is_out ? (i * 91) % 4096 - 2048 : (i * 37) % 512 - 256;
    endcase
  endfunction

  function automatic longint la(input longint x);
    longint e, t;
    e = 0;
    t = x;
    while (t > 1) begin
      t = t / 2;
      e++;
    end
    return e * 256 + (x * 256) / (longint'(1) << e) - 256;
  endfunction

  function automatic logic [16:0] model(input longint si, input longint so);
    longint g;
    if (so == 0) return {1'b1, 16'h8000};
    if (si == 0) return {1'b1, 16'h7fff};
    g = ((la(so) - la(si)) * 1541) >>> 8;
    if (g > 32767) g = 32767;
    if (g < -32768) g = -32768;
    return {1'b0, 16'(g)};
  endfunction

  // use_model=0 takes the hand-derived expected value.
  task automatic run(input int kind, input bit gap, input int mid_at, input bit b2b,
                     input bit use_model, input logic [16:0] exp);
    longint si, so;
    int vi, vo;
    logic [16:0] got, want;
    si = 0;
    so = 0;
    if (!b2b) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    sample_valid = 1'b1;
    in_sample  = 12'h7ff;
    out_sample = 12'h000;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gap) begin
        sample_valid = 1'b0;
        in_sample  = 12'h800;
        out_sample = 12'h7ff;
        @(posedge clk);
        #1;
      end
      vi = gen(kind, i, 1'b0);
      vo = gen(kind, i, 1'b1);
      sample_valid = 1'b1;
      in_sample  = 12'(vi);
      out_sample = 12'(vo);
      start = (i == mid_at);
      si += (vi < 0) ? -vi : vi;
      so += (vo < 0) ? -vo : vo;
      @(negedge clk);
      if (i == 0) chk("busy_first_sample", busy, 1);
      if (mid_at >= 0 && i == mid_at + 1) chk("busy_after_mid_start", busy, 1);
      @(posedge clk);
      #1;
    end
    sample_valid = 1'b0;
    start = 1'b0;
    want = use_model ? model(si, so) : exp;
    exp_q.push_back(want);
    @(negedge clk);
    chk("rv_low_log", result_valid, 0);
    chk("busy_log", busy, 1);
    @(negedge clk);
    chk("rv_low_scale", result_valid, 0);
    @(negedge clk);
    chk("rv_pulse", result_valid, 1);
    chk("busy_fall", busy, 0);
    #1;
    if (got_q.size() == 0) begin
      chk("result_present", 0, 1);
      void'(exp_q.pop_front());
    end else begin
      got  = got_q.pop_front();
      want = exp_q.pop_front();
      chk("gain_db", got[15:0], want[15:0]);
      chk("zero_flag", got[16], want[16]);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sample_valid = 1'b0;
    in_sample = '0;
    out_sample = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_rv", result_valid, 0);
    chk("reset_gain", gain_db, 0);
    chk("reset_zf", zero_flag, 0);

    run(0, 1'b0, -1, 1'b0, 1'b0, {1'b0, 16'h1468});
    run(0, 1'b0, -1, 1'b1, 1'b0, {1'b0, 16'h1468});
    @(negedge clk);
    chk("rv_single_pulse", result_valid, 0);
    run(1, 1'b0, -1, 1'b0, 1'b0, {1'b0, 16'h0000});
    run(2, 1'b0, -1, 1'b0, 1'b0, {1'b1, 16'h8000});
    run(3, 1'b0, -1, 1'b0, 1'b0, {1'b1, 16'h7fff});
    run(0, 1'b1, 50, 1'b0, 1'b0, {1'b0, 16'h1468});

    // Abort after 100 samples; held result must clear.
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      sample_valid = 1'b1;
      in_sample  = 12'(gen(0, i, 1'b0));
      out_sample = 12'(gen(3, i, 1'b1));
      @(posedge clk);
      #1;
    end
    sample_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_gain", gain_db, 0);
    chk("abort_zf", zero_flag, 0);

    run(0, 1'b0, -1, 1'b0, 1'b0, {1'b0, 16'h1468});
    run(4, 1'b0, -1, 1'b0, 1'b1, '0);

    repeat (4) @(negedge clk);
    chk("no_extra_results", got_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
